// File: rtl/tpumac_if.sv
// tpumac_if: operand/accumulator bundle for one systolic MAC cell
//   master: drives en, WrEn, sat_en, Ain, Bin, Cin; observes Aout, Bout, Cout, busy, ovf, mac_cnt
//   slave : the cell side of the same signals
interface tpumac_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int CNT_W   = 8
);
  logic                      en;
  logic                      WrEn;
  logic                      sat_en;
  logic signed [BITS_AB-1:0] Ain;
  logic signed [BITS_AB-1:0] Bin;
  logic signed [BITS_C-1:0]  Cin;
  logic signed [BITS_AB-1:0] Aout;
  logic signed [BITS_AB-1:0] Bout;
  logic signed [BITS_C-1:0]  Cout;
  logic                      busy;
  logic                      ovf;
  logic [CNT_W-1:0]          mac_cnt;
  modport master (
    output en, WrEn, sat_en, Ain, Bin, Cin,
    input  Aout, Bout, Cout, busy, ovf, mac_cnt
  );
  modport slave (
    input  en, WrEn, sat_en, Ain, Bin, Cin,
    output Aout, Bout, Cout, busy, ovf, mac_cnt
  );
endinterface

// File: rtl/tpumac_pipe.sv
// tpumac_pipe: pipelined systolic MAC cell with saturating/wrapping accumulate
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   m (slave)  : en forwards A/B and launches Ain*Bin; WrEn loads Cin and flushes;
//                sat_en picks saturate/wrap; Cout accumulator; busy/ovf/mac_cnt status
module tpumac_pipe #(
  parameter int BITS_AB    = 8,
  parameter int BITS_C     = 16,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = 8
) (
  input logic     clk,
  input logic     rst_n,
  tpumac_if.slave m
);
  localparam int PW = 2 * BITS_AB;
  if (BITS_C < PW) begin : g_bad_c
    $error("tpumac_pipe: BITS_C must be >= 2*BITS_AB");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("tpumac_pipe: MUL_STAGES must be in 1..4");
  end
  logic signed [PW-1:0]     prod [MUL_STAGES];
  logic [MUL_STAGES-1:0]    vld;
  logic signed [PW-1:0]     a_x, b_x, p_new;
  logic signed [BITS_C:0]   s;
  logic signed [BITS_C-1:0] sat_v, acc_v;
  logic                     acc, ov;
  always_comb begin
    a_x   = PW'(m.Ain);
    b_x   = PW'(m.Bin);
    p_new = a_x * b_x;
    s     = (BITS_C + 1)'(m.Cout) + (BITS_C + 1)'(prod[MUL_STAGES-1]);
    ov    = s[BITS_C] != s[BITS_C-1];
    sat_v = s[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}};
    acc_v = ov && m.sat_en ? sat_v : s[BITS_C-1:0];
    acc   = vld[MUL_STAGES-1] && !m.WrEn;
  end
  assign m.busy = |vld;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m.Aout    <= '0;
      m.Bout    <= '0;
      m.Cout    <= '0;
      m.ovf     <= 1'b0;
      m.mac_cnt <= '0;
      vld       <= '0;
      for (int i = 0; i < MUL_STAGES; i++) prod[i] <= '0;
    end else begin
      if (m.en) begin
        m.Aout <= m.Ain;
        m.Bout <= m.Bin;
      end
      prod[0] <= p_new;
      vld[0]  <= m.en && !m.WrEn;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod[i] <= prod[i-1];
        vld[i]  <= vld[i-1] && !m.WrEn;
      end
      m.Cout    <= m.WrEn ? m.Cin : acc ? acc_v : m.Cout;
      m.ovf     <= m.WrEn ? 1'b0 : m.ovf || (acc && ov);
      m.mac_cnt <= m.WrEn ? '0 : acc && !(&m.mac_cnt) ? m.mac_cnt + CNT_W'(1) : m.mac_cnt;
    end
  end
endmodule

// File: tb/tb_tpumac_pipe.sv
// tb_tpumac_pipe: directed self-checking bench for tpumac_pipe
module tb_tpumac_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  tpumac_if #(.BITS_AB(8), .BITS_C(16), .CNT_W(8)) bus ();
  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .MUL_STAGES(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic load(input logic signed [15:0] v);
    bus.WrEn = 1'b1;
    bus.Cin  = v;
    cyc();
    bus.WrEn = 1'b0;
  endtask
  initial begin
    logic signed [7:0]  sa [4] = '{8'sd1, -8'sd3, 8'sd7, -8'sd128};
    logic signed [7:0]  sb [4] = '{8'sd2, 8'sd5, 8'sd7, -8'sd128};
    logic signed [15:0] se [4] = '{16'sd2, -16'sd13, 16'sd36, 16'sd16420};
    bus.en = 0; bus.WrEn = 0; bus.sat_en = 0; bus.Ain = 0; bus.Bin = 0; bus.Cin = 0;
    cyc(); cyc();
    chk("rst_aout", bus.Aout, 0);
    chk("rst_cout", bus.Cout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_cnt", bus.mac_cnt, 0);
    rst_n = 1'b1;
    // latency
    load(0);
    bus.en = 1; bus.Ain = 3; bus.Bin = 4;
    cyc();
    bus.en = 0;
    chk("lat_aout", bus.Aout, 3);
    chk("lat_bout", bus.Bout, 4);
    chk("lat_cout_k", bus.Cout, 0);
    chk("lat_busy_k", bus.busy, 1);
    cyc();
    chk("lat_cout_k1", bus.Cout, 0);
    chk("lat_busy_k1", bus.busy, 1);
    cyc();
    chk("lat_cout_k2", bus.Cout, 12);
    chk("lat_busy_k2", bus.busy, 0);
    chk("lat_cnt", bus.mac_cnt, 1);
    // back-to-back stream with signed extremes
    load(0);
    for (int i = 0; i < 6; i++) begin
      bus.en  = i < 4;
      bus.Ain = i < 4 ? sa[i] : 8'sd0;
      bus.Bin = i < 4 ? sb[i] : 8'sd0;
      cyc();
      if (i >= 2) chk($sformatf("stream_%0d", i - 2), bus.Cout, se[i-2]);
    end
    bus.en = 0;
    chk("stream_cnt", bus.mac_cnt, 4);
    chk("stream_ovf", bus.ovf, 0);
    // positive overflow, saturate then wrap
    for (int w = 0; w < 2; w++) begin
      bus.sat_en = w == 0;
      load(32760);
      chk($sformatf("ovf_clr_%0d", w), bus.ovf, 0);
      bus.en = 1; bus.Ain = 127; bus.Bin = 127;
      cyc();
      bus.en = 0;
      cyc(); cyc();
      chk($sformatf("ovf_cout_%0d", w), bus.Cout, w == 0 ? 32767 : -16647);
      chk($sformatf("ovf_flag_%0d", w), bus.ovf, 1);
    end
    // negative saturation
    bus.sat_en = 1;
    load(-32760);
    bus.en = 1; bus.Ain = -128; bus.Bin = 127;
    cyc();
    bus.en = 0;
    cyc(); cyc();
    chk("neg_sat_cout", bus.Cout, -32768);
    chk("neg_sat_ovf", bus.ovf, 1);
    // flush in-flight product with load
    bus.en = 1; bus.Ain = 10; bus.Bin = 10;
    cyc();
    bus.en = 0; bus.WrEn = 1; bus.Cin = 5;
    cyc();
    bus.WrEn = 0;
    chk("flush_cout_k1", bus.Cout, 5);
    chk("flush_busy", bus.busy, 0);
    chk("flush_cnt", bus.mac_cnt, 0);
    chk("flush_ovf", bus.ovf, 0);
    cyc();
    chk("flush_cout_k2", bus.Cout, 5);
    // simultaneous WrEn and en
    bus.WrEn = 1; bus.en = 1; bus.Cin = 100; bus.Ain = 2; bus.Bin = 2;
    cyc();
    bus.WrEn = 0; bus.en = 0;
    chk("both_aout", bus.Aout, 2);
    chk("both_bout", bus.Bout, 2);
    chk("both_busy", bus.busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("both_cout_%0d", i), bus.Cout, 100);
      chk($sformatf("both_busy_%0d", i), bus.busy, 0);
      cyc();
    end
    // mac_cnt saturates at all-ones
    load(0);
    bus.en = 1; bus.Ain = 0; bus.Bin = 0;
    for (int i = 0; i < 260; i++) cyc();
    bus.en = 0;
    cyc(); cyc();
    chk("cnt_sat", bus.mac_cnt, 255);
    // reset between edges with products in flight
    bus.sat_en = 1;
    load(32760);
    bus.en = 1; bus.Ain = 127; bus.Bin = 127;
    cyc(); cyc(); cyc();
    bus.en = 0;
    chk("pre_rst_cout", bus.Cout, 32767);
    chk("pre_rst_ovf", bus.ovf, 1);
    chk("pre_rst_busy", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cout", bus.Cout, 32767);
    chk("mid_rst_ovf", bus.ovf, 1);
    chk("mid_rst_aout", bus.Aout, 127);
    cyc();
    chk("post_rst_cout", bus.Cout, 0);
    chk("post_rst_aout", bus.Aout, 0);
    chk("post_rst_bout", bus.Bout, 0);
    chk("post_rst_ovf", bus.ovf, 0);
    chk("post_rst_cnt", bus.mac_cnt, 0);
    chk("post_rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("after_rst_cout", bus.Cout, 0);
    chk("after_rst_cnt", bus.mac_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
